reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per register, minimum 2.
REQ-002 SHALL have parameter DEPTH, default 8: number of registers, minimum 2.
REQ-003 SHALL have parameter RESET_VAL, default 1: value loaded into every register on reset.
REQ-004 SHALL derive AW = clog2(DEPTH) and BW = clog2(WIDTH) locally; neither SHALL be a port parameter.
REQ-005 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port: rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 Port: en  input  1  operation strobe; op, waddr, wdata and bsel are sampled only when en=1.
REQ-008 Port: op  input  3  operation code; encodings are listed in REQ-013.
REQ-009 Port: waddr  input  AW  target register of the operation.
REQ-010 Port: wdata  input  WIDTH  load data for OP_LOAD.
REQ-011 Port: bsel  input  BW  bit index for OP_BSET and OP_BCLR.
REQ-012 Ports: raddr input AW; rdata output WIDTH (combinational read); z output 1 (zero flag); c output 1 (carry/borrow flag); hit output 1 (result-is-zero pulse).

Function
REQ-013 Op encodings SHALL be: 0 NOP, 1 LOAD, 2 BSET, 3 BCLR, 4 INC, 5 DEC, 6 CLR, 7 SWAP.
REQ-014 When en=1 and op is not NOP, reg[waddr] SHALL take the op result at the next rising clk edge: 1-cycle latency.
REQ-015 When en=0 or op=NOP, all registers and z/c SHALL hold; hit SHALL be 0.
REQ-016 LOAD result = wdata; CLR result = 0.
REQ-017 BSET sets bit bsel of the register and BCLR clears it; all other bits are unchanged.
REQ-018 If bsel >= WIDTH, BSET and BCLR SHALL leave the register unchanged and SHALL still update z.
REQ-019 INC result = (reg+1) mod 2^WIDTH, and c SHALL be 1 exactly when all-ones wraps to 0.
REQ-020 DEC result = (reg-1) mod 2^WIDTH, and c SHALL be 0 exactly when 0 wraps to all-ones (borrow); otherwise c=1.
REQ-021 SWAP SHALL exchange the upper and lower halves, each floor(WIDTH/2) bits wide.
REQ-022 For odd WIDTH, the MSB SHALL stay in place during SWAP.
REQ-023 z SHALL be a registered flag, updated by every non-NOP op to (result == 0).
REQ-024 c SHALL update only on INC and DEC and SHALL hold on all other ops.
REQ-025 hit SHALL be a one-cycle registered pulse, asserted the cycle after an INC or DEC whose result is 0 (skip-on-zero support).
REQ-026 rdata SHALL equal reg[raddr] from the array contents, with no write bypass.
REQ-027 When raddr == waddr during a write cycle, rdata SHALL show the old value until the edge.
REQ-028 An out-of-range waddr (>= DEPTH, non-power-of-two DEPTH) SHALL cause no register write.
REQ-029 z SHALL still update on an out-of-range waddr, computed from a source value of 0.
REQ-030 An out-of-range raddr SHALL return rdata = 0.
REQ-031 Operations on different cycles to the same address SHALL be back-to-back capable: each op SHALL use the value committed by the previous edge.

Reset
REQ-032 While rst=0, every register SHALL be RESET_VAL truncated to WIDTH, z=0, c=0 and hit=0, independent of clk.
REQ-033 rst deassertion SHALL take effect synchronously to clk: the first op is accepted on the first rising edge with rst=1.
REQ-034 An operation whose edge coincides with rst=0 SHALL be discarded.

Structure
REQ-035 Package reg_bank_pkg SHALL hold the op typedef (3-bit enum) and the OP_* constants.
REQ-036 The package SHALL hold no width-dependent types.
REQ-037 Sub-module reg_bank_alu SHALL be purely combinational: (op, src, wdata, bsel) -> (result, carry, carry_valid).
REQ-038 reg_bank SHALL own the register array, the flags and the address decode.

Verification
REQ-039 Reset with defaults, then read every address -> rdata=1 for all 8 registers; z=0, c=0.
REQ-040 LOAD 8'hFF to reg 3, then INC reg 3 -> reg3=0, z=1, c=1, hit pulses exactly one cycle.
REQ-041 CLR reg 2, then DEC reg 2 -> reg2=8'hFF, c=0, z=0, hit=0.
REQ-042 LOAD 8'hA5 to reg 5, SWAP -> 8'h5A; then BCLR bsel=1 -> 8'h58; then BSET bsel=7 -> 8'hD8.
REQ-043 WIDTH=5, DEPTH=6: SWAP on 5'b10110 -> 5'b11001; LOAD with waddr=7 -> no register changes.
REQ-044 Assert rst mid-stream with en=1 and op=INC -> all registers read RESET_VAL immediately (asynchronously) and the INC is lost.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: operation codes only.
// Nothing here depends on the data width, so every bank size can share this package.
package reg_bank_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_BSET = 3'd2,
        OP_BCLR = 3'd3,
        OP_INC  = 3'd4,
        OP_DEC  = 3'd5,
        OP_CLR  = 3'd6,
        OP_SWAP = 3'd7
    } op_e;

endpackage

// File: rtl/reg_bank_alu.sv
// Combinational operation unit: computes the new register value for one op.
// It also reports a carry/borrow flag; carry_valid marks the ops that own that flag.
module reg_bank_alu
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int BW    = $clog2(WIDTH)
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] wdata,
    input  logic [BW-1:0]    bsel,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             carry_valid
);

    // Halves exchanged by SWAP; for odd WIDTH the MSB is left out and keeps its place.
    localparam int HALF = WIDTH / 2;

    // Per-op result; a bit index beyond WIDTH matches no bit, so the value passes through.
    always_comb begin
        result      = src;
        carry       = 1'b0;
        carry_valid = 1'b0;
        case (op)
            OP_LOAD: result = wdata;
            OP_BSET: begin
                for (int i = 0; i < WIDTH; i++)
                    if (BW'(i) == bsel) result[i] = 1'b1;
            end
            OP_BCLR: begin
                for (int i = 0; i < WIDTH; i++)
                    if (BW'(i) == bsel) result[i] = 1'b0;
            end
            OP_INC: begin
                result      = src + WIDTH'(1);
                carry       = &src;          // all-ones wraps to zero
                carry_valid = 1'b1;
            end
            OP_DEC: begin
                result      = src - WIDTH'(1);
                carry       = |src;          // 0 means a borrow happened
                carry_valid = 1'b1;
            end
            OP_CLR:  result = '0;
            OP_SWAP: begin
                for (int i = 0; i < HALF; i++) begin
                    result[i]        = src[i+HALF];
                    result[i+HALF]   = src[i];
                end
            end
            default: result = src;
        endcase
    end

endmodule

// File: rtl/reg_bank.sv
// Small register bank with a single-op datapath, z/c flags and a zero-result pulse.
// Reads are combinational from the array with no write bypass.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 8,
    parameter  int RESET_VAL = 1,
    localparam int AW        = $clog2(DEPTH),
    localparam int BW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [BW-1:0]    bsel,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             z,
    output logic             c,
    output logic             hit
);

    localparam logic [WIDTH-1:0] RST_WORD = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] src;
    logic             wr_ok;
    logic             act;
    op_e              opc;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_cv;

    assign opc = op_e'(op);
    assign act = en && (opc != OP_NOP);

    // Write-side decode; an unmapped address reads as 0 and blocks the write.
    always_comb begin
        src   = '0;
        wr_ok = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (AW'(i) == waddr) begin
                src   = mem[i];
                wr_ok = 1'b1;
            end
        end
    end

    // Read port straight from the array; unmapped addresses return 0.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++)
            if (AW'(i) == raddr) rdata = mem[i];
    end

    reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
        .op          (opc),
        .src         (src),
        .wdata       (wdata),
        .bsel        (bsel),
        .result      (alu_res),
        .carry       (alu_c),
        .carry_valid (alu_cv)
    );

    // Register array: commit the op result to the addressed entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_WORD;
        end else if (act && wr_ok) begin
            for (int i = 0; i < DEPTH; i++)
                if (AW'(i) == waddr) mem[i] <= alu_res;
        end
    end

    // Flags: z on every op, c only on INC/DEC, hit pulses for a zero INC/DEC result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z   <= 1'b0;
            c   <= 1'b0;
            hit <= 1'b0;
        end else begin
            hit <= act && alu_cv && (alu_res == '0);
            if (act) z <= (alu_res == '0);
            if (act && alu_cv) c <= alu_c;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: default 8x8 bank plus a 5-bit, 6-deep bank.
module tb_reg_bank;
    import reg_bank_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance
    logic       en1;
    logic [2:0] op1, waddr1, bsel1, raddr1;
    logic [7:0] wdata1, rdata1;
    logic       z1, c1, hit1;

    // WIDTH=5, DEPTH=6 instance
    logic       en2;
    logic [2:0] op2, waddr2, bsel2, raddr2;
    logic [4:0] wdata2, rdata2;
    logic       z2, c2, hit2;

    reg_bank u1 (
        .clk(clk), .rst(rst), .en(en1), .op(op1), .waddr(waddr1), .wdata(wdata1),
        .bsel(bsel1), .raddr(raddr1), .rdata(rdata1), .z(z1), .c(c1), .hit(hit1)
    );

    reg_bank #(.WIDTH(5), .DEPTH(6), .RESET_VAL(1)) u2 (
        .clk(clk), .rst(rst), .en(en2), .op(op2), .waddr(waddr2), .wdata(wdata2),
        .bsel(bsel2), .raddr(raddr2), .rdata(rdata2), .z(z2), .c(c2), .hit(hit2)
    );

    typedef struct {
        logic       en;
        logic [2:0] op;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic [2:0] bsel;
        logic [2:0] raddr;
        logic [7:0] rd;
        logic       z;
        logic       c;
        logic       hit;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t t1[$];
    vec_t t2[$];

    function automatic vec_t mk(input logic e, input logic [2:0] o, input logic [2:0] a,
                                input logic [7:0] d, input logic [2:0] b, input logic [2:0] r,
                                input logic [7:0] rd, input logic zz, input logic cc,
                                input logic hh);
        vec_t v;
        v.en = e; v.op = o; v.waddr = a; v.wdata = d; v.bsel = b; v.raddr = r;
        v.rd = rd; v.z = zz; v.c = cc; v.hit = hh;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run1(input vec_t v, input int idx);
        @(negedge clk);
        en1 = v.en; op1 = v.op; waddr1 = v.waddr; wdata1 = v.wdata;
        bsel1 = v.bsel; raddr1 = v.raddr;
        @(posedge clk);
        #1;
        chk($sformatf("u1[%0d].rdata", idx), 32'(rdata1), 32'(v.rd));
        chk($sformatf("u1[%0d].z", idx), 32'(z1), 32'(v.z));
        chk($sformatf("u1[%0d].c", idx), 32'(c1), 32'(v.c));
        chk($sformatf("u1[%0d].hit", idx), 32'(hit1), 32'(v.hit));
    endtask

    task automatic run2(input vec_t v, input int idx);
        @(negedge clk);
        en2 = v.en; op2 = v.op; waddr2 = v.waddr; wdata2 = v.wdata[4:0];
        bsel2 = v.bsel; raddr2 = v.raddr;
        @(posedge clk);
        #1;
        chk($sformatf("u2[%0d].rdata", idx), 32'(rdata2), 32'(v.rd));
        chk($sformatf("u2[%0d].z", idx), 32'(z2), 32'(v.z));
        chk($sformatf("u2[%0d].c", idx), 32'(c2), 32'(v.c));
        chk($sformatf("u2[%0d].hit", idx), 32'(hit2), 32'(v.hit));
    endtask

    initial begin
        // Default bank: reset contents, then the main op sequences
        for (int i = 0; i < 8; i++) t1.push_back(mk(0, OP_NOP, 0, 8'h00, 0, 3'(i), 8'h01, 0, 0, 0));
        t1.push_back(mk(1, OP_LOAD, 3, 8'hFF, 0, 3, 8'hFF, 0, 0, 0));
        t1.push_back(mk(1, OP_INC,  3, 8'h00, 0, 3, 8'h00, 1, 1, 1));
        t1.push_back(mk(0, OP_NOP,  3, 8'h00, 0, 3, 8'h00, 1, 1, 0));
        t1.push_back(mk(1, OP_CLR,  2, 8'h00, 0, 2, 8'h00, 1, 1, 0));
        t1.push_back(mk(1, OP_DEC,  2, 8'h00, 0, 2, 8'hFF, 0, 0, 0));
        t1.push_back(mk(1, OP_LOAD, 5, 8'hA5, 0, 5, 8'hA5, 0, 0, 0));
        t1.push_back(mk(1, OP_SWAP, 5, 8'h00, 0, 5, 8'h5A, 0, 0, 0));
        t1.push_back(mk(1, OP_BCLR, 5, 8'h00, 1, 5, 8'h58, 0, 0, 0));
        t1.push_back(mk(1, OP_BSET, 5, 8'h00, 7, 5, 8'hD8, 0, 0, 0));
        t1.push_back(mk(0, OP_LOAD, 5, 8'h00, 0, 5, 8'hD8, 0, 0, 0));
        t1.push_back(mk(1, OP_NOP,  5, 8'h00, 0, 5, 8'hD8, 0, 0, 0));
        t1.push_back(mk(1, OP_LOAD, 1, 8'h01, 0, 1, 8'h01, 0, 0, 0));
        t1.push_back(mk(1, OP_DEC,  1, 8'h00, 0, 1, 8'h00, 1, 1, 1));
        t1.push_back(mk(1, OP_DEC,  1, 8'h00, 0, 1, 8'hFF, 0, 0, 0));
        t1.push_back(mk(1, OP_INC,  1, 8'h00, 0, 1, 8'h00, 1, 1, 1));
        t1.push_back(mk(1, OP_BSET, 0, 8'h00, 0, 0, 8'h01, 0, 1, 0));
        t1.push_back(mk(1, OP_BCLR, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0));
        t1.push_back(mk(1, OP_INC,  4, 8'h00, 0, 4, 8'h02, 0, 0, 0));
        t1.push_back(mk(0, OP_NOP,  0, 8'h00, 0, 3, 8'h00, 0, 0, 0));
        t1.push_back(mk(0, OP_NOP,  0, 8'h00, 0, 2, 8'hFF, 0, 0, 0));

        // Odd-width, non-power-of-two bank
        t2.push_back(mk(0, OP_NOP,  0, 8'h00, 0, 7, 8'h00, 0, 0, 0));
        t2.push_back(mk(0, OP_NOP,  0, 8'h00, 0, 5, 8'h01, 0, 0, 0));
        t2.push_back(mk(1, OP_LOAD, 4, 8'h16, 0, 4, 8'h16, 0, 0, 0));
        t2.push_back(mk(1, OP_SWAP, 4, 8'h00, 0, 4, 8'h19, 0, 0, 0));
        t2.push_back(mk(1, OP_LOAD, 7, 8'h00, 0, 4, 8'h19, 1, 0, 0));
        t2.push_back(mk(1, OP_BSET, 4, 8'h00, 6, 4, 8'h19, 0, 0, 0));
        t2.push_back(mk(1, OP_BCLR, 4, 8'h00, 5, 4, 8'h19, 0, 0, 0));
        t2.push_back(mk(1, OP_LOAD, 3, 8'h1F, 0, 3, 8'h1F, 0, 0, 0));
        t2.push_back(mk(1, OP_INC,  3, 8'h00, 0, 3, 8'h00, 1, 1, 1));
        t2.push_back(mk(1, OP_DEC,  6, 8'h00, 0, 6, 8'h00, 0, 0, 0));
        t2.push_back(mk(1, OP_CLR,  7, 8'h00, 0, 0, 8'h01, 1, 0, 0));
        t2.push_back(mk(0, OP_NOP,  0, 8'h00, 0, 0, 8'h01, 1, 0, 0));
        t2.push_back(mk(0, OP_NOP,  0, 8'h00, 0, 1, 8'h01, 1, 0, 0));
        t2.push_back(mk(0, OP_NOP,  0, 8'h00, 0, 2, 8'h01, 1, 0, 0));
        t2.push_back(mk(0, OP_NOP,  0, 8'h00, 0, 3, 8'h00, 1, 0, 0));
        t2.push_back(mk(0, OP_NOP,  0, 8'h00, 0, 4, 8'h19, 1, 0, 0));
        t2.push_back(mk(0, OP_NOP,  0, 8'h00, 0, 5, 8'h01, 1, 0, 0));

        rst = 1'b0;
        en1 = 0; op1 = 0; waddr1 = 0; wdata1 = 0; bsel1 = 0; raddr1 = 0;
        en2 = 0; op2 = 0; waddr2 = 0; wdata2 = 0; bsel2 = 0; raddr2 = 0;
        #12;
        chk("reset.z", 32'(z1), 32'd0);
        chk("reset.hit", 32'(hit1), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (t1[k]) run1(t1[k], k);
        foreach (t2[k]) run2(t2[k], k);
        @(negedge clk);
        en1 = 0; en2 = 0;

        // Read of the register being written shows the old value until the edge
        @(negedge clk);
        en1 = 1; op1 = OP_LOAD; waddr1 = 6; wdata1 = 8'h33; raddr1 = 6;
        #1;
        chk("rw_same.before", 32'(rdata1), 32'h01);
        @(posedge clk);
        #1;
        chk("rw_same.after", 32'(rdata1), 32'h33);

        // Set all flags, then reset mid-stream with an INC pending
        run1(mk(1, OP_LOAD, 7, 8'hFF, 0, 7, 8'hFF, 0, 0, 0), 100);
        run1(mk(1, OP_INC,  7, 8'h00, 0, 7, 8'h00, 1, 1, 1), 101);
        @(negedge clk);
        en1 = 1; op1 = OP_INC; waddr1 = 0; raddr1 = 7;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst.reg7", 32'(rdata1), 32'h01);
        chk("async_rst.z", 32'(z1), 32'd0);
        chk("async_rst.c", 32'(c1), 32'd0);
        chk("async_rst.hit", 32'(hit1), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            raddr1 = 3'(i);
            #1;
            chk($sformatf("rst_read[%0d]", i), 32'(rdata1), 32'h01);
        end
        // Release between edges: INC stays presented and takes effect on the next edge
        @(negedge clk);
        rst = 1'b1;
        raddr1 = 0;
        #1;
        chk("rst_release.hold", 32'(rdata1), 32'h01);
        @(posedge clk);
        #1;
        chk("rst_release.first_op", 32'(rdata1), 32'h02);
        chk("rst_release.z", 32'(z1), 32'd0);
        en1 = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
